// File: rtl/logic_unit_bist_if.sv
// Bus between the logic-unit self-test engine, its controller and the unit under test.
// Handshake: start is a level sampled only while the engine is idle; busy is high from the
// accepted start edge until the end of the run, and done is a one-cycle pulse when results settle.
interface logic_unit_bist_if;
    logic        start;
    logic [1:0]  op_sel;
    logic [31:0] dut_a;
    logic [31:0] dut_b;
    logic [31:0] dut_s;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] test_count;
    logic [15:0] error_count;
    logic [31:0] fail_a;
    logic [31:0] fail_b;
    logic [31:0] fail_s;

    modport master (
        output start, op_sel, dut_s,
        input  dut_a, dut_b, busy, done, pass, test_count, error_count,
        input  fail_a, fail_b, fail_s
    );

    modport slave (
        input  start, op_sel, dut_s,
        output dut_a, dut_b, busy, done, pass, test_count, error_count,
        output fail_a, fail_b, fail_s
    );
endinterface

// File: rtl/logic_unit_bist.sv
// Stimulus/response engine for 32-bit logic units: applies 5 directed plus NUM_RANDOM
// LFSR vectors, compares each result one cycle later, and reports counts and the first failure.
module logic_unit_bist #(
    parameter int unsigned NUM_RANDOM = 16,
    parameter logic [31:0] SEED_A     = 32'hACE12468,
    parameter logic [31:0] SEED_B     = 32'h13579BDF
) (
    input  logic             clk,
    input  logic             rst,
    logic_unit_bist_if.slave bus,
    output logic [1:0]       o_dbg_state
);
    localparam int unsigned NUM_VEC   = 5 + NUM_RANDOM;
    localparam logic [10:0] LAST_IDX  = 11'(NUM_VEC - 1);
    localparam logic [31:0] LFSR_MASK = 32'h80200003;
    localparam logic [31:0] INIT_A    = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] INIT_B    = (SEED_B == 32'd0) ? 32'd1 : SEED_B;

    typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_op;
    logic [10:0] r_idx;
    logic [31:0] r_lfsr_a, r_lfsr_b;
    logic [31:0] r_dut_a, r_dut_b;
    logic        r_busy, r_done, r_pass;
    logic [15:0] r_test_count, r_error_count;
    logic [31:0] r_fail_a, r_fail_b, r_fail_s;
    logic [31:0] w_vec_a, w_vec_b;
    logic [31:0] w_golden;
    logic        w_mismatch;
    logic        w_last;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'd0);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.start) w_next_state = S_CHECK;
            S_APPLY: w_next_state = S_CHECK;
            S_CHECK: w_next_state = w_last ? S_DONE : S_APPLY;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Vector 0 is driven directly on start; this table serves indices 1 and up.
    always_comb begin
        w_vec_a = r_lfsr_a;
        w_vec_b = r_lfsr_b;
        case (r_idx)
            11'd1: begin w_vec_a = 32'h80000001; w_vec_b = 32'hFFFFFFFF; end
            11'd2: begin w_vec_a = 32'hFFFFFFFF; w_vec_b = 32'hFFFFFFFF; end
            11'd3: begin w_vec_a = 32'h00000003; w_vec_b = 32'h00000001; end
            11'd4: begin w_vec_a = 32'h00000001; w_vec_b = 32'h7FFFFFFF; end
            default: ;
        endcase
    end

    always_comb begin
        w_golden = 32'd0;
        case (r_op)
            2'b00: w_golden = r_dut_a & r_dut_b;
            2'b01: w_golden = r_dut_a | r_dut_b;
            2'b10: w_golden = r_dut_a ^ r_dut_b;
            2'b11: w_golden = ~(r_dut_a | r_dut_b);
            default: ;
        endcase
    end

    assign w_mismatch = (bus.dut_s != w_golden);
    assign w_last     = (r_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op          <= 2'b00;
            r_idx         <= 11'd0;
            r_lfsr_a      <= INIT_A;
            r_lfsr_b      <= INIT_B;
            r_dut_a       <= 32'd0;
            r_dut_b       <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_test_count  <= 16'd0;
            r_error_count <= 16'd0;
            r_fail_a      <= 32'd0;
            r_fail_b      <= 32'd0;
            r_fail_s      <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op          <= bus.op_sel;
                        r_idx         <= 11'd0;
                        r_lfsr_a      <= INIT_A;
                        r_lfsr_b      <= INIT_B;
                        r_dut_a       <= 32'd0;
                        r_dut_b       <= 32'd0;
                        r_busy        <= 1'b1;
                        r_pass        <= 1'b0;
                        r_test_count  <= 16'd0;
                        r_error_count <= 16'd0;
                        r_fail_a      <= 32'd0;
                        r_fail_b      <= 32'd0;
                        r_fail_s      <= 32'd0;
                    end
                end
                S_APPLY: begin
                    r_dut_a <= w_vec_a;
                    r_dut_b <= w_vec_b;
                    if (r_idx >= 11'd5) begin
                        r_lfsr_a <= lfsr_step(r_lfsr_a);
                        r_lfsr_b <= lfsr_step(r_lfsr_b);
                    end
                end
                S_CHECK: begin
                    r_test_count <= r_test_count + 16'd1;
                    r_idx        <= r_idx + 11'd1;
                    // A zero error count means this is the first mismatch of the run.
                    if (w_mismatch) begin
                        if (r_error_count != 16'hFFFF) r_error_count <= r_error_count + 16'd1;
                        if (r_error_count == 16'd0) begin
                            r_fail_a <= r_dut_a;
                            r_fail_b <= r_dut_b;
                            r_fail_s <= bus.dut_s;
                        end
                    end
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (r_error_count == 16'd0) && !w_mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_a       = r_dut_a;
    assign bus.dut_b       = r_dut_b;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.pass        = r_pass;
    assign bus.test_count  = r_test_count;
    assign bus.error_count = r_error_count;
    assign bus.fail_a      = r_fail_a;
    assign bus.fail_b      = r_fail_b;
    assign bus.fail_s      = r_fail_s;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_logic_unit_bist.sv
// Bench for logic_unit_bist: a behavioural logic-unit model feeds dut_s, a run-level model
// predicts every vector and the final report, and a negedge monitor checks against the queue.
module tb_logic_unit_bist;
    localparam int N = 5 + 16;
    localparam logic [31:0] SEED_A = 32'hACE12468;
    localparam logic [31:0] SEED_B = 32'h13579BDF;

    typedef struct {
        int          k;
        logic [15:0] tc;
        logic [15:0] ec;
        logic        pass;
        logic [31:0] fa, fb, fs;
    } run_t;

    logic        clk;
    logic        rst;
    logic [1:0]  dbg_state;
    logic [1:0]  unit_op;
    bit          unit_fault;
    logic [31:0] unit_s;
    int          cyc;
    int          n_total;
    int          n_bad;
    logic [31:0] ref_a [N];
    logic [31:0] ref_b [N];
    run_t        exp_q [$];

    logic_unit_bist_if bus ();

    logic_unit_bist dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] logic_op(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // unit under test model
    always_comb begin
        unit_s = logic_op(unit_op, bus.dut_a, bus.dut_b);
        if (unit_fault) unit_s[0] = 1'b0;
    end
    assign bus.dut_s = unit_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void build_vectors();
        logic [31:0] sa, sb;
        ref_a[0] = 32'h00000000; ref_b[0] = 32'h00000000;
        ref_a[1] = 32'h80000001; ref_b[1] = 32'hFFFFFFFF;
        ref_a[2] = 32'hFFFFFFFF; ref_b[2] = 32'hFFFFFFFF;
        ref_a[3] = 32'h00000003; ref_b[3] = 32'h00000001;
        ref_a[4] = 32'h00000001; ref_b[4] = 32'h7FFFFFFF;
        sa = SEED_A;
        sb = SEED_B;
        for (int i = 5; i < N; i++) begin
            ref_a[i] = sa;
            ref_b[i] = sb;
            sa = (sa >> 1) ^ (sa[0] ? 32'h80200003 : 32'h0);
            sb = (sb >> 1) ^ (sb[0] ? 32'h80200003 : 32'h0);
        end
    endfunction

    function automatic run_t model_run(input int k, input logic [1:0] op, input logic [1:0] uop,
                                       input bit fault);
        run_t r;
        logic [31:0] g, s;
        r.k = k; r.tc = 16'(N); r.ec = 16'd0;
        r.fa = 32'd0; r.fb = 32'd0; r.fs = 32'd0;
        for (int i = 0; i < N; i++) begin
            g = logic_op(op, ref_a[i], ref_b[i]);
            s = logic_op(uop, ref_a[i], ref_b[i]);
            if (fault) s[0] = 1'b0;
            if (s != g) begin
                if (r.ec == 16'd0) begin
                    r.fa = ref_a[i]; r.fb = ref_b[i]; r.fs = s;
                end
                if (r.ec != 16'hFFFF) r.ec = r.ec + 16'd1;
            end
        end
        r.pass = (r.ec == 16'd0);
        return r;
    endfunction

    // monitor: vector timing while a run is expected, final report on done
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            int rel;
            rel = cyc - exp_q[0].k;
            if (rel >= 0 && rel < 2 * N && (rel % 2) == 0) begin
                chk($sformatf("vec%0d_a", rel / 2), bus.dut_a, ref_a[rel / 2]);
                chk($sformatf("vec%0d_b", rel / 2), bus.dut_b, ref_b[rel / 2]);
                chk("busy_in_run", 32'(bus.busy), 32'd1);
            end
            if (bus.done) begin
                // done seen after edge k+2N-1 is the value sampled at edge k+2N
                chk("done_cycle", 32'(rel + 1), 32'(2 * N));
                chk("busy_at_done", 32'(bus.busy), 32'd0);
                chk("test_count", 32'(bus.test_count), 32'(exp_q[0].tc));
                chk("error_count", 32'(bus.error_count), 32'(exp_q[0].ec));
                chk("pass", 32'(bus.pass), 32'(exp_q[0].pass));
                chk("fail_a", bus.fail_a, exp_q[0].fa);
                chk("fail_b", bus.fail_b, exp_q[0].fb);
                chk("fail_s", bus.fail_s, exp_q[0].fs);
                void'(exp_q.pop_front());
            end
        end else if (bus.done) begin
            chk("unexpected_done", 32'(bus.done), 32'd0);
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] op, input logic [1:0] uop, input bit fault,
                             output int k);
        unit_op    = uop;
        unit_fault = fault;
        bus.op_sel = op;
        bus.start  = 1'b1;
        k = cyc + 1;
        exp_q.push_back(model_run(k, op, uop, fault));
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (exp_q.size() > 0 && cnt < 300) begin
            tick();
            cnt++;
        end
        if (exp_q.size() > 0) begin
            chk("run_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic tick_until(input int target);
        int cnt;
        cnt = 0;
        while (cyc < target && cnt < 300) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        int k;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op_sel = 2'b00;
        unit_op    = 2'b00;
        unit_fault = 1'b0;
        build_vectors();
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pass", 32'(bus.pass), 32'd0);
        chk("rst_test_count", 32'(bus.test_count), 32'd0);
        chk("rst_error_count", 32'(bus.error_count), 32'd0);
        chk("rst_dut_a", bus.dut_a, 32'd0);
        chk("rst_dut_b", bus.dut_b, 32'd0);
        chk("rst_fail_a", bus.fail_a, 32'd0);
        chk("rst_fail_b", bus.fail_b, 32'd0);
        chk("rst_fail_s", bus.fail_s, 32'd0);

        // directed: correct AND, stuck-low bit 0, AND unit judged as NOR
        start_run(2'b00, 2'b00, 1'b0, k); wait_idle();
        start_run(2'b00, 2'b00, 1'b1, k); wait_idle();
        start_run(2'b11, 2'b00, 1'b0, k); wait_idle();

        for (int r = 0; r < 6; r++) begin
            start_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      bit'($urandom_range(0, 1)), k);
            wait_idle();
        end

        // abort with reset at edge k+10, then a clean run
        start_run(2'b01, 2'b01, 1'b0, k);
        tick_until(k + 9);
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_test_count", 32'(bus.test_count), 32'd0);
        chk("abort_error_count", 32'(bus.error_count), 32'd0);
        repeat (3) tick();
        start_run(2'b10, 2'b10, 1'b0, k); wait_idle();

        // starts at edge k+5 and during the DONE cycle are ignored
        start_run(2'b00, 2'b00, 1'b0, k);
        tick_until(k + 4);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick_until(k + 2 * N - 1);
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        wait_idle();
        repeat (4) tick();
        chk("ignored_start_busy", 32'(bus.busy), 32'd0);

        // start held high: back-to-back runs, second begins at edge k+2N+1
        unit_op    = 2'b00;
        unit_fault = 1'b0;
        bus.op_sel = 2'b00;
        bus.start  = 1'b1;
        k = cyc + 1;
        exp_q.push_back(model_run(k, 2'b00, 2'b00, 1'b0));
        exp_q.push_back(model_run(k + 2 * N + 1, 2'b00, 2'b00, 1'b0));
        tick_until(k + 2 * N + 1);
        bus.start = 1'b0;
        wait_idle();
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
